steer_en: RTL and testbench

STEER_EN -- requirements
Module: steer_en

---
 rtl/steer_en.sv | 96 +++++++++
 tb/tb_steer_en.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/steer_en.sv
// Steering-enable FSM: decides from left/right load-cell samples whether a rider is
// present (IDLE/WAIT) and has stood balanced long enough to allow steering (STEER).
module steer_en #(
    parameter logic [11:0] MIN_RIDER_WEIGHT = 12'h200,
    parameter int          FAST_SIM         = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    input  logic        ld_vld,
    output logic        en_steer,
    output logic        rider_off
);

    localparam int unsigned TMR_W = (FAST_SIM != 0) ? 15 : 26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STEER = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [11:0]        lft_q, rght_q;

    logic [12:0]        sum;
    logic signed [12:0] diff;
    logic [12:0]        neg_diff;
    logic [11:0]        abs_diff;
    logic [16:0]        sum_x15;
    logic               sum_gt_min;
    logic               diff_gt_1_4;
    logic               diff_gt_15_16;
    logic               tmr_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            lft_q  <= '0;
            rght_q <= '0;
        end else if (ld_vld) begin
            lft_q  <= lft_ld;
            rght_q <= rght_ld;
        end
    end

    // Operands are zero-extended so the difference spans -4095..+4095 and its magnitude fits 12 bits.
    always_comb begin
        sum           = {1'b0, lft_q} + {1'b0, rght_q};
        diff          = signed'({1'b0, lft_q}) - signed'({1'b0, rght_q});
        neg_diff      = 13'(-diff);
        abs_diff      = diff[12] ? neg_diff[11:0] : diff[11:0];
        sum_x15       = {4'b0000, sum} * 17'd15;
        sum_gt_min    = sum > {1'b0, MIN_RIDER_WEIGHT};
        diff_gt_1_4   = {1'b0, abs_diff} > (sum >> 2);
        diff_gt_15_16 = {5'b00000, abs_diff} > (sum_x15 >> 4);
        tmr_full      = &tmr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // Loss of rider weight is tested first in every state so it overrides any imbalance.
    always_comb begin
        state_d = state_q;
        tmr_d   = '0;
        case (state_q)
            IDLE: begin
                if (sum_gt_min) state_d = WAIT;
            end
            WAIT: begin
                if (!sum_gt_min)     state_d = IDLE;
                else if (diff_gt_1_4) tmr_d  = '0;
                else if (tmr_full)   state_d = STEER;
                else                 tmr_d   = tmr_q + 1'b1;
            end
            STEER: begin
                if (!sum_gt_min)        state_d = IDLE;
                else if (diff_gt_15_16) state_d = WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    assign en_steer  = (state_q == STEER);
    assign rider_off = (state_q == IDLE);

endmodule

// File: tb/tb_steer_en.sv
// Directed bench for steer_en (FAST_SIM=1, 15-bit timer): vector table for the
// rider-detect thresholds plus hand sequences for the timed WAIT/STEER behaviour.
module tb_steer_en;

    logic        clk;
    logic        rst;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        ld_vld;
    logic        en_steer;
    logic        rider_off;

    int unsigned vecs;
    int unsigned errs;

    localparam int unsigned FULL_CNT = 32768;

    steer_en #(.MIN_RIDER_WEIGHT(12'h200), .FAST_SIM(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .lft_ld   (lft_ld),
        .rght_ld  (rght_ld),
        .ld_vld   (ld_vld),
        .en_steer (en_steer),
        .rider_off(rider_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #(1_500_000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [11:0] l;
        logic [11:0] r;
        logic        exp_off;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [11:0] l, input logic [11:0] r);
        lft_ld  = l;
        rght_ld = r;
        ld_vld  = 1'b1;
        tick();
        ld_vld  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk(input string name, input logic en_exp, input logic off_exp);
        vecs++;
        if (en_steer !== en_exp || rider_off !== off_exp) begin
            errs++;
            $display("FAIL %s: got en_steer=%b rider_off=%b, want en_steer=%b rider_off=%b",
                     name, en_steer, rider_off, en_exp, off_exp);
        end
    endtask

    task automatic hold(input string name, input int unsigned n, input logic en_exp, input logic off_exp);
        int unsigned bad;
        bad = 0;
        for (int unsigned i = 0; i < n; i++) begin
            tick();
            if (en_steer !== en_exp || rider_off !== off_exp || (en_steer === 1'b1 && rider_off === 1'b1))
                bad++;
        end
        vecs++;
        if (bad != 0) begin
            errs++;
            $display("FAIL %s: %0d of %0d cycles differed from en_steer=%b rider_off=%b (last en_steer=%b rider_off=%b)",
                     name, bad, n, en_exp, off_exp, en_steer, rider_off);
        end
    endtask

    task automatic count_to_steer(input string name, input int unsigned exp_n);
        int unsigned n;
        n = 0;
        while (en_steer !== 1'b1 && n < FULL_CNT + 2000) begin
            tick();
            n++;
        end
        vecs++;
        if (n != exp_n || en_steer !== 1'b1) begin
            errs++;
            $display("FAIL %s: en_steer rose after %0d cycles (en_steer=%b), want %0d cycles",
                     name, n, en_steer, exp_n);
        end
    endtask

    vec_t tbl[8];

    initial begin
        vecs    = 0;
        errs    = 0;
        rst     = 1'b1;
        ld_vld  = 1'b0;
        lft_ld  = '0;
        rght_ld = '0;

        tbl[0] = '{"below_min",      12'h100, 12'h0F0, 1'b1};
        tbl[1] = '{"equal_min",      12'h100, 12'h100, 1'b1};
        tbl[2] = '{"just_above_min", 12'h101, 12'h100, 1'b0};
        tbl[3] = '{"sum_13bit",      12'hFFF, 12'h201, 1'b0};
        tbl[4] = '{"one_sided_load", 12'h000, 12'h201, 1'b0};
        tbl[5] = '{"balanced_rider", 12'h150, 12'h100, 1'b0};
        tbl[6] = '{"light_pair",     12'h080, 12'h080, 1'b1};
        tbl[7] = '{"max_load",       12'hFFF, 12'hFFF, 1'b0};

        // Reset state, then hold with no samples
        tick();
        rst = 1'b0;
        chk("reset_state", 1'b0, 1'b1);
        hold("idle_no_vld", 1000, 1'b0, 1'b1);

        // Rider-detect threshold table, each from a fresh reset
        foreach (tbl[i]) begin
            do_reset();
            strobe(tbl[i].l, tbl[i].r);
            chk({tbl[i].name, "_latency"}, 1'b0, 1'b1);
            tick();
            chk(tbl[i].name, 1'b0, tbl[i].exp_off);
            hold({tbl[i].name, "_hold"}, 4, 1'b0, tbl[i].exp_off);
        end

        // Under-weight rider never leaves IDLE
        do_reset();
        strobe(12'h100, 12'h0F0);
        hold("light_stays_idle", 1000, 1'b0, 1'b1);

        // Balanced rider: WAIT two cycles after strobe, STEER a full count later
        strobe(12'h150, 12'h100);
        chk("bal_strobe_edge", 1'b0, 1'b1);
        tick();
        chk("bal_enter_wait", 1'b0, 0);
        count_to_steer("first_full_count", FULL_CNT);
        chk("in_steer", 1'b1, 1'b0);

        // Exactly at the 15/16 threshold: stays in STEER
        strobe(12'h3E0, 12'h020);
        hold("diff_eq_15_16", 5, 1'b1, 1'b0);

        // Beyond 15/16 threshold: back to WAIT
        strobe(12'h400, 12'h010);
        chk("imbal_strobe_edge", 1'b1, 1'b0);
        tick();
        chk("imbal_to_wait", 1'b0, 1'b0);

        // Partial balanced count, then imbalance must clear (not pause) the timer
        strobe(12'h150, 12'h100);
        hold("partial_count", 1000, 1'b0, 1'b0);
        strobe(12'h200, 12'h080);
        hold("imbal_hold_wait", 10000, 1'b0, 1'b0);

        // Right-heavy sample with diff exactly sum/4 counts as balanced; full count restarts
        strobe(12'h120, 12'h1E0);
        count_to_steer("restart_full_count", FULL_CNT);

        // Rider steps off from STEER
        strobe(12'h080, 12'h080);
        chk("off_strobe_edge", 1'b1, 1'b0);
        tick();
        chk("steer_to_idle", 1'b0, 1'b1);
        hold("idle_after_off", 20, 1'b0, 1'b1);

        // Reset mid-WAIT with a heavy sample strobed in the same cycle
        strobe(12'h150, 12'h100);
        tick();
        chk("wait_again", 1'b0, 1'b0);
        hold("wait_mid_count", 500, 1'b0, 1'b0);
        rst     = 1'b1;
        lft_ld  = 12'h150;
        rght_ld = 12'h100;
        ld_vld  = 1'b1;
        tick();
        rst     = 1'b0;
        ld_vld  = 1'b0;
        chk("rst_over_ld", 1'b0, 1'b1);
        hold("rst_cleared_samples", 20, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
